// File: rtl/bp_pkg.sv
// Shared definitions for the gshare/bimodal branch predictor.
//   DEPTH / CNT_MAX : table geometry for the default configuration
//   bp_depth        : table depth for a given index width
//   bp_cnt_max      : saturation ceiling for a given counter width
//   bp_hash         : index fold (addr XOR zero-extended history, or addr alone)
//   bp_sat_next     : saturating up/down counter step
package bp_pkg;

  localparam int IDX_W_DEF = 5;
  localparam int CNT_W_DEF = 2;
  localparam int DEPTH     = 2**IDX_W_DEF;
  localparam int CNT_MAX   = 2**CNT_W_DEF - 1;

  function automatic int bp_depth(input int idx_w);
    return 1 << idx_w;
  endfunction

  function automatic int bp_cnt_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

  // ghr arrives zero-extended, so history only perturbs the low GHR_W bits.
  function automatic logic [31:0] bp_hash(input logic [31:0] addr,
                                          input logic [31:0] ghr,
                                          input logic        gshare);
    return gshare ? (addr ^ ghr) : addr;
  endfunction

  // Operates on a wide container; callers cast back to their own width and
  // pass their own all-ones value as the ceiling.
  function automatic logic [63:0] bp_sat_next(input logic [63:0] cnt,
                                              input logic [63:0] cmax,
                                              input logic        taken);
    if (taken) return (cnt == cmax)  ? cnt : cnt + 64'd1;
    else       return (cnt == 64'd0) ? cnt : cnt - 64'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter_next.sv
// Combinational saturating counter step.
//   cnt   : current value (W bits)
//   taken : 1 = increment toward all-ones, 0 = decrement toward zero
//   nxt   : next value
// Used for predictor table entries and, with taken tied high, for the
// saturating performance counters.
module bp_sat_counter_next
  import bp_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] cnt,
  input  logic         taken,
  output logic [W-1:0] nxt
);

  if (W < 1 || W > 64) begin : g_bad_w
    $error("bp_sat_counter_next: W must be 1..64");
  end

  localparam logic [63:0] CMAX = (W >= 64) ? {64{1'b1}} : ((64'd1 << W) - 64'd1);

  assign nxt = W'(bp_sat_next(64'(cnt), CMAX, taken));

endmodule

// File: rtl/branch_predictor_gshare.sv
// Branch direction predictor: table of CNT_W-bit saturating counters indexed
// by PC bits, optionally XORed with a non-speculative global history (gshare).
//   clk, arst_n        : clock, synchronous active-low reset
//   rd_addr            : PC index bits at fetch
//   prediction         : combinational, counter MSB of the selected entry
//   pred_ghr           : history used for this prediction, returned at resolve
//   upd_en/addr/ghr    : resolution strobe, PC bits and prediction-time history
//   upd_taken/upd_pred : actual outcome and issued prediction
//   perf_updates       : saturating count of resolutions
//   perf_mispred       : saturating count of resolutions with upd_pred != upd_taken
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int IDX_W    = 5,
  parameter int CNT_W    = 2,
  parameter int GHR_W    = 5,
  parameter int GSHARE   = 1,
  parameter int INIT_CNT = 1,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic              prediction,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic              upd_en,
  input  logic [IDX_W-1:0]  upd_addr,
  input  logic [GHR_W-1:0]  upd_ghr,
  input  logic              upd_taken,
  input  logic              upd_pred,
  output logic [PERF_W-1:0] perf_updates,
  output logic [PERF_W-1:0] perf_mispred
);

  if (IDX_W < 1 || IDX_W > 20) begin : g_bad_idx
    $error("branch_predictor_gshare: IDX_W out of range");
  end
  if (CNT_W < 1 || CNT_W > 30) begin : g_bad_cnt
    $error("branch_predictor_gshare: CNT_W out of range");
  end
  if (GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_ghr
    $error("branch_predictor_gshare: GHR_W must be 1..IDX_W");
  end
  if (INIT_CNT < 0 || INIT_CNT > bp_cnt_max(CNT_W)) begin : g_bad_init
    $error("branch_predictor_gshare: INIT_CNT out of range");
  end
  if (PERF_W < 1 || PERF_W > 64) begin : g_bad_perf
    $error("branch_predictor_gshare: PERF_W must be 1..64");
  end

  localparam int               TBL_DEPTH = bp_depth(IDX_W);
  localparam logic [CNT_W-1:0] INIT_V    = CNT_W'(INIT_CNT);
  localparam logic             HASH_EN   = (GSHARE != 0);

  logic [TBL_DEPTH-1:0][CNT_W-1:0] tbl;
  logic [TBL_DEPTH-1:0][CNT_W-1:0] tbl_nxt;
  logic [GHR_W-1:0]                ghr, ghr_nxt;
  logic [IDX_W-1:0]                rd_idx, upd_idx;
  logic [PERF_W-1:0]               upd_cnt_nxt, mis_cnt_nxt;
  logic                            mispred;

  assign rd_idx  = IDX_W'(bp_hash(32'(rd_addr),  32'(ghr),     HASH_EN));
  assign upd_idx = IDX_W'(bp_hash(32'(upd_addr), 32'(upd_ghr), HASH_EN));

  // Read side sees registered state only: a same-cycle update to the same
  // entry is not forwarded.
  assign prediction = tbl[rd_idx][CNT_W-1];
  assign pred_ghr   = ghr;
  assign mispred    = upd_pred ^ upd_taken;

  // One next-value stage per entry; the write decode picks the resolved one.
  for (genvar g = 0; g < TBL_DEPTH; g++) begin : g_ent
    bp_sat_counter_next #(.W(CNT_W)) u_cnt (
      .cnt   (tbl[g]),
      .taken (upd_taken),
      .nxt   (tbl_nxt[g])
    );
  end

  if (GHR_W == 1) begin : g_ghr1
    assign ghr_nxt = upd_taken;
  end else begin : g_ghrn
    assign ghr_nxt = {ghr[GHR_W-2:0], upd_taken};
  end

  bp_sat_counter_next #(.W(PERF_W)) u_perf_upd (
    .cnt   (perf_updates),
    .taken (1'b1),
    .nxt   (upd_cnt_nxt)
  );

  bp_sat_counter_next #(.W(PERF_W)) u_perf_mis (
    .cnt   (perf_mispred),
    .taken (1'b1),
    .nxt   (mis_cnt_nxt)
  );

  // Reset takes priority over a coincident update, which is dropped.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      tbl          <= {TBL_DEPTH{INIT_V}};
      ghr          <= '0;
      perf_updates <= '0;
      perf_mispred <= '0;
    end else if (upd_en) begin
      tbl[upd_idx] <= tbl_nxt[upd_idx];
      ghr          <= ghr_nxt;
      perf_updates <= upd_cnt_nxt;
      if (mispred) perf_mispred <= mis_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench: three predictor instances share one stimulus bus
// (bimodal, gshare, gshare with 2-bit perf counters); expectations are
// hand-derived per instance.
module tb_branch_predictor_gshare;

  logic       clk = 1'b0;
  logic       arst_n = 1'b1;
  logic [4:0] rd_addr = '0;
  logic       upd_en = 1'b0;
  logic [4:0] upd_addr = '0;
  logic [4:0] upd_ghr = '0;
  logic       upd_taken = 1'b0;
  logic       upd_pred = 1'b0;

  logic        bi_pred, gs_pred, p2_pred;
  logic [4:0]  bi_ghr, gs_ghr, p2_ghr;
  logic [31:0] bi_pu, bi_pm, gs_pu, gs_pm;
  logic [1:0]  p2_pu, p2_pm;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor_gshare #(.GSHARE(0)) dut_bi (
    .clk(clk), .arst_n(arst_n), .rd_addr(rd_addr), .prediction(bi_pred),
    .pred_ghr(bi_ghr), .upd_en(upd_en), .upd_addr(upd_addr), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_pred(upd_pred),
    .perf_updates(bi_pu), .perf_mispred(bi_pm)
  );

  branch_predictor_gshare #(.GSHARE(1)) dut_gs (
    .clk(clk), .arst_n(arst_n), .rd_addr(rd_addr), .prediction(gs_pred),
    .pred_ghr(gs_ghr), .upd_en(upd_en), .upd_addr(upd_addr), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_pred(upd_pred),
    .perf_updates(gs_pu), .perf_mispred(gs_pm)
  );

  branch_predictor_gshare #(.GSHARE(1), .PERF_W(2)) dut_p2 (
    .clk(clk), .arst_n(arst_n), .rd_addr(rd_addr), .prediction(p2_pred),
    .pred_ghr(p2_ghr), .upd_en(upd_en), .upd_addr(upd_addr), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_pred(upd_pred),
    .perf_updates(p2_pu), .perf_mispred(p2_pm)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; reads settle 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    rd_addr = a;
    #1;
  endtask

  task automatic upd(input logic [4:0] a, input logic [4:0] h, input logic t, input logic p);
    upd_en = 1'b1; upd_addr = a; upd_ghr = h; upd_taken = t; upd_pred = p;
    tick();
    upd_en = 1'b0;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
  endtask

  initial begin
    // ---- reset defaults
    do_reset();
    chk("rst_bi_pu", bi_pu, 32'd0);
    chk("rst_bi_pm", bi_pm, 32'd0);
    chk("rst_p2_pu", 32'(p2_pu), 32'd0);
    chk("rst_gs_ghr", 32'(gs_ghr), 32'd0);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i));
      chk($sformatf("rst_gs_pred%0d", i), 32'(gs_pred), 32'd0);
      chk($sformatf("rst_bi_pred%0d", i), 32'(bi_pred), 32'd0);
      tick();
    end

    // ---- bimodal saturation on entry 7: 01->10->11->11 then 10->01
    upd(5'd7, 5'd0, 1'b1, 1'b1); rd(5'd7); chk("bi_t1", 32'(bi_pred), 32'd1);
    upd(5'd7, 5'd0, 1'b1, 1'b1); rd(5'd7); chk("bi_t2", 32'(bi_pred), 32'd1);
    upd(5'd7, 5'd0, 1'b1, 1'b1); rd(5'd7); chk("bi_t3", 32'(bi_pred), 32'd1);
    upd(5'd7, 5'd0, 1'b0, 1'b0); rd(5'd7); chk("bi_n1", 32'(bi_pred), 32'd1);
    upd(5'd7, 5'd0, 1'b0, 1'b0); rd(5'd7); chk("bi_n2", 32'(bi_pred), 32'd0);
    chk("ghr_shift_bi", 32'(bi_ghr), 32'b11100);
    chk("ghr_shift_gs", 32'(gs_ghr), 32'b11100);
    chk("pu5_bi", bi_pu, 32'd5);

    // ---- history and hashing
    do_reset();
    chk("rst2_pu", bi_pu, 32'd0);
    upd(5'd3, 5'd0, 1'b1, 1'b1);
    upd(5'd3, 5'd0, 1'b0, 1'b0);
    upd(5'd3, 5'd0, 1'b1, 1'b1);
    chk("gs_ghr_101", 32'(gs_ghr), 32'b00101);
    // entry 3 is 10 here; the next update hashes to 3^5 = 6
    upd(5'd3, 5'b00101, 1'b1, 1'b1);
    chk("gs_ghr_1011", 32'(gs_ghr), 32'b01011);
    rd(5'd13); chk("gs_ent6", 32'(gs_pred), 32'd1);   // 13^11 = 6
    chk("bi_ent13", 32'(bi_pred), 32'd0);              // bimodal: entry 13 untouched
    rd(5'd8);  chk("gs_ent3", 32'(gs_pred), 32'd1);    // 8^11 = 3, still 10
    rd(5'd14); chk("gs_ent5", 32'(gs_pred), 32'd0);    // 14^11 = 5, untouched
    tick();
    rd(5'd3);  chk("bi_ent3", 32'(bi_pred), 32'd1);    // bimodal entry 3 now 11

    // ---- read during write on bimodal entry 4 (counter 01)
    tick();
    rd_addr = 5'd4;
    upd_en = 1'b1; upd_addr = 5'd4; upd_ghr = 5'd0; upd_taken = 1'b1; upd_pred = 1'b0;
    #1;
    chk("rdw_pred_old", 32'(bi_pred), 32'd0);
    chk("rdw_ghr_old", 32'(bi_ghr), 32'b01011);
    tick();
    upd_en = 1'b0;
    chk("rdw_pred_new", 32'(bi_pred), 32'd1);
    chk("rdw_ghr_new", 32'(bi_ghr), 32'b10111);

    // ---- perf counters: 10 updates, mispredicts at 1, 4, 8
    do_reset();
    for (int i = 0; i < 10; i++) begin
      upd(5'(i), 5'd0, i[0], i[0] ^ (i == 1 || i == 4 || i == 8));
      if (i == 4) begin
        chk("p2_pu_sat5", 32'(p2_pu), 32'd3);
        chk("p2_pm_5", 32'(p2_pm), 32'd2);
      end
    end
    chk("bi_pu10", bi_pu, 32'd10);
    chk("bi_pm3", bi_pm, 32'd3);
    chk("gs_pu10", gs_pu, 32'd10);
    chk("p2_pu_sat10", 32'(p2_pu), 32'd3);
    chk("p2_pm_sat10", 32'(p2_pm), 32'd3);

    // ---- reset coincident with an update on a saturated entry
    upd(5'd9, 5'd0, 1'b1, 1'b1);
    upd(5'd9, 5'd0, 1'b1, 1'b1);
    rd(5'd9); chk("sat9_pre", 32'(bi_pred), 32'd1);
    arst_n = 1'b0;
    upd_en = 1'b1; upd_addr = 5'd9; upd_ghr = 5'd0; upd_taken = 1'b1; upd_pred = 1'b0;
    tick();
    arst_n = 1'b1; upd_en = 1'b0;
    rd(5'd9);
    chk("mid_bi_pred", 32'(bi_pred), 32'd0);
    chk("mid_gs_pred", 32'(gs_pred), 32'd0);
    chk("mid_bi_ghr", 32'(bi_ghr), 32'd0);
    chk("mid_gs_ghr", 32'(gs_ghr), 32'd0);
    chk("mid_bi_pu", bi_pu, 32'd0);
    chk("mid_bi_pm", bi_pm, 32'd0);
    chk("mid_p2_pu", 32'(p2_pu), 32'd0);
    // one taken update from INIT lands on 10, proving entry 9 was re-initialised
    upd(5'd9, 5'd0, 1'b1, 1'b1);
    rd(5'd9);
    chk("mid_bi_after", 32'(bi_pred), 32'd1);
    chk("mid_bi_pu1", bi_pu, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
